// File: rtl/mac_burst_pkg.sv
// Shared widths, fixed-point helpers and FSM encoding for mac_burst.
package mac_burst_pkg;

    // Wide signed scratch type for alignment and range checks.
    typedef logic signed [127:0] wide_t;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    function automatic int in_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int prod_w(input int int_bits, input int frac_bits);
        return 2 * (int_bits + frac_bits);
    endfunction

    function automatic int out_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    // Guard bits cover max_len products plus rounding, so the accumulator never wraps.
    function automatic int acc_w(input int int_bits, input int frac_bits, input int max_len);
        return int_bits + frac_bits + $clog2(max_len) + 2;
    endfunction

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Arithmetic right shift with round half up.
    function automatic wide_t round_shift(input wide_t v, input int sh);
        wide_t half;
        if (sh <= 0) begin
            return v;
        end
        half = wide_t'(1) <<< (sh - 1);
        return (v + half) >>> sh;
    endfunction

    // True when v is representable as a w-bit two's-complement value.
    function automatic logic fits(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        return (v <= hi) && (v >= lo);
    endfunction

endpackage

// File: rtl/mac_burst_align_sat.sv
// fxp_align_sat: aligns a signed fixed-point value to a new fractional
// position (round half up when dropping bits) and narrows it to dst_w,
// clamping or wrapping depending on sat.
module fxp_align_sat
    import mac_burst_pkg::*;
#(
    parameter int src_w    = 42,
    parameter int src_frac = 22,
    parameter int dst_w    = 32,
    parameter int dst_frac = 22,
    parameter int sat      = 1
) (
    input  logic signed [src_w-1:0] src,
    output logic signed [dst_w-1:0] dst,
    output logic                    clamped
);

    wide_t ext;
    wide_t aligned;

    assign ext = wide_t'(src);

    if (dst_frac >= src_frac) begin : g_shl
        assign aligned = ext <<< (dst_frac - src_frac);
    end else begin : g_rnd
        assign aligned = round_shift(ext, src_frac - dst_frac);
    end

    // Narrow to dst_w, clamping to the nearest extreme when saturation is on.
    always_comb begin
        dst     = aligned[dst_w-1:0];
        clamped = 1'b0;
        if (sat != 0 && !fits(aligned, dst_w)) begin
            clamped = 1'b1;
            dst     = aligned[127] ? {1'b1, {(dst_w-1){1'b0}}}
                                   : {1'b0, {(dst_w-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_burst.sv
// mac_burst: streaming signed fixed-point multiply-accumulate over a
// runtime-programmable burst length, one result per burst.
//
// state | meaning
// IDLE  | next accepted beat starts a burst; len_i is sampled
// BURST | rem beats still to come; len_i ignored
module mac_burst
    import mac_burst_pkg::*;
#(
    parameter int int_in_p   = 1,
    parameter int frac_in_p  = 11,
    parameter int int_out_p  = 10,
    parameter int frac_out_p = 22,
    parameter int max_len_p  = 256,
    parameter int sat_p      = 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [in_w(int_in_p, frac_in_p)-1:0]     a_i,
    input  logic [in_w(int_in_p, frac_in_p)-1:0]     b_i,
    input  logic [len_w(max_len_p)-1:0]              len_i,
    input  logic                                     valid_i,
    output logic                                     ready_o,
    output logic                                     valid_o,
    input  logic                                     ready_i,
    output logic [out_w(int_out_p, frac_out_p)-1:0]  data_o,
    output logic                                     sat_o
);

    localparam int PROD_W = prod_w(int_in_p, frac_in_p);
    localparam int OUT_W  = out_w(int_out_p, frac_out_p);
    localparam int ACC_W  = acc_w(int_out_p, frac_out_p, max_len_p);
    localparam int LEN_W  = len_w(max_len_p);

    logic                     stall;
    logic                     accept;
    logic                     last;
    state_t                   state;
    state_t                   state_nxt;
    logic [LEN_W-1:0]         rem;
    logic [LEN_W-1:0]         rem_nxt;
    logic [LEN_W-1:0]         eff_len;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod1;
    logic                     v1;
    logic                     last1;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_add;
    logic signed [ACC_W-1:0]  sum;
    logic signed [OUT_W-1:0]  res;
    logic                     res_sat;

    // Output-side backpressure freezes the whole block, input side included.
    assign stall   = valid_o & ~ready_i;
    assign ready_o = ~stall;
    assign accept  = valid_i & ready_o;

    assign prod = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));

    if (frac_out_p >= 2 * frac_in_p) begin : g_shl
        assign acc_add = ACC_W'(wide_t'(prod1) <<< (frac_out_p - 2 * frac_in_p));
    end else begin : g_rnd
        assign acc_add = ACC_W'(round_shift(wide_t'(prod1), 2 * frac_in_p - frac_out_p));
    end

    assign sum = acc + acc_add;

    fxp_align_sat #(
        .src_w    (ACC_W),
        .src_frac (frac_out_p),
        .dst_w    (OUT_W),
        .dst_frac (frac_out_p),
        .sat      (sat_p)
    ) u_out_sat (
        .src     (sum),
        .dst     (res),
        .clamped (res_sat)
    );

    // Burst-length sequencing: decide which accepted beat closes the burst.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        last      = 1'b0;
        if (len_i == '0) begin
            eff_len = LEN_W'(1);
        end else if (len_i > LEN_W'(max_len_p)) begin
            eff_len = LEN_W'(max_len_p);
        end else begin
            eff_len = len_i;
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    if (eff_len == LEN_W'(1)) begin
                        last = 1'b1;
                    end else begin
                        rem_nxt   = eff_len - LEN_W'(1);
                        state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    rem_nxt = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state and remaining-beat counter; only move on an accepted beat.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Stage 1: full-precision product with its end-of-burst marker.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            prod1 <= '0;
        end else if (!stall) begin
            v1    <= accept;
            last1 <= last;
            if (accept) begin
                prod1 <= prod;
            end
        end
    end

    // Stage 2: accumulate; on the last beat publish the result and restart from zero.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc     <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
            sat_o   <= 1'b0;
        end else if (!stall) begin
            valid_o <= v1 & last1;
            if (v1) begin
                if (last1) begin
                    acc    <= '0;
                    data_o <= res;
                    sat_o  <= res_sat;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_burst.sv
// Self-checking bench for mac_burst: default instance plus variants for
// long-burst saturation/wrap and coarse output precision.
module tb_mac_burst;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [11:0] a_i;
    logic [11:0] b_i;
    logic [10:0] len_i;
    logic        valid_i;
    logic        ready_i;

    logic        ready_o, valid_o, sat_o;
    logic [31:0] data_o;
    logic        big_ready, big_valid, big_sat;
    logic [31:0] big_data;
    logic        wrap_ready, wrap_valid, wrap_sat;
    logic [31:0] wrap_data;
    logic        f11_ready, f11_valid, f11_sat;
    logic [20:0] f11_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    logic        got_sat_q[$];
    logic [20:0] f11_q[$];

    always #5 clk_i = ~clk_i;

    mac_burst dut (
        .clk_i(clk_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .len_i(len_i[8:0]),
        .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .sat_o(sat_o)
    );

    mac_burst #(.max_len_p(1024), .sat_p(1)) dut_big (
        .clk_i(clk_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .len_i(len_i),
        .valid_i(valid_i), .ready_o(big_ready), .valid_o(big_valid), .ready_i(ready_i),
        .data_o(big_data), .sat_o(big_sat)
    );

    mac_burst #(.max_len_p(1024), .sat_p(0)) dut_wrap (
        .clk_i(clk_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .len_i(len_i),
        .valid_i(valid_i), .ready_o(wrap_ready), .valid_o(wrap_valid), .ready_i(ready_i),
        .data_o(wrap_data), .sat_o(wrap_sat)
    );

    mac_burst #(.frac_out_p(11)) dut_f11 (
        .clk_i(clk_i), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .len_i(len_i[8:0]),
        .valid_i(valid_i), .ready_o(f11_ready), .valid_o(f11_valid), .ready_i(ready_i),
        .data_o(f11_data), .sat_o(f11_sat)
    );

    // Result monitor: a transfer happens at the next rising edge.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (valid_o && ready_i) begin
                got_q.push_back(data_o);
                got_sat_q.push_back(sat_o);
            end
            if (f11_valid && ready_i) f11_q.push_back(f11_data);
        end
    end

    // Reference: sum of per-beat products at fo fractional bits (inputs are Q1.11),
    // then clamp to ow bits when sat is set; the caller truncates for wrap.
    function automatic longint ref_burst(input logic [11:0] as[$], input logic [11:0] bs[$],
                                         input int fo, input int ow, input bit sat,
                                         output bit clamped);
        longint sum, p, hi, lo;
        sum = 0;
        for (int i = 0; i < as.size(); i++) begin
            p = longint'($signed(as[i])) * longint'($signed(bs[i]));
            if (fo >= 22) p = p <<< (fo - 22);
            else p = (p + (longint'(1) <<< (21 - fo))) >>> (22 - fo);
            sum += p;
        end
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -hi - 1;
        clamped = 1'b0;
        if (sat && sum > hi) begin sum = hi; clamped = 1'b1; end
        else if (sat && sum < lo) begin sum = lo; clamped = 1'b1; end
        return sum;
    endfunction

    task automatic do_reset();
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; len_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        got_q.delete(); got_sat_q.delete(); f11_q.delete();
    endtask

    task automatic send_beat(input logic [11:0] a, input logic [11:0] b, input logic [10:0] len);
        int n = 0;
        a_i = a; b_i = b; len_i = len; valid_i = 1'b1;
        @(negedge clk_i);
        while (!ready_o && n < 200) begin @(negedge clk_i); n++; end
        if (!ready_o) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout ready_o=%b required 1", ready_o);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_results(input int n);
        for (int t = 0; t < 300 && got_q.size() < n; t++) @(posedge clk_i);
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL result_count got %0d required %0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", valid_o); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h required 0", data_o); end
        checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat got %b required 0", sat_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", ready_o); end
    endtask

    task automatic test_basic();
        do_reset();
        for (int j = 0; j < 4; j++) send_beat(12'h400, 12'h400, (j == 0) ? 11'd4 : 11'd0);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b required 0", valid_o); end
        @(posedge clk_i); #1;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_latency_valid got %b required 1", valid_o); end
        checks++; if (data_o !== 32'h00400000) begin errors++; $display("FAIL basic_data got %h required 00400000", data_o); end
        checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL basic_sat got %b required 0", sat_o); end
        @(posedge clk_i); #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_single_pulse got %b required 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int j = 0; j < 2; j++) send_beat(12'h400, 12'hC00, (j == 0) ? 11'd2 : 11'd0);
        for (int j = 0; j < 3; j++) send_beat(12'h400, 12'hC00, (j == 0) ? 11'd3 : 11'd7);
        wait_results(2);
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== 32'hFFE00000) begin errors++; $display("FAIL b2b_first got %h required FFE00000", got_q[0]); end
            checks++; if (got_q[1] !== 32'hFFD00000) begin errors++; $display("FAIL b2b_second got %h required FFD00000", got_q[1]); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        ready_i = 1'b0;
        fork
            begin
                for (int j = 0; j < 2; j++) send_beat(12'h400, 12'h400, (j == 0) ? 11'd2 : 11'd0);
                for (int j = 0; j < 3; j++) send_beat(12'h400, 12'hC00, (j == 0) ? 11'd3 : 11'd1);
            end
            begin
                int n = 0;
                @(negedge clk_i);
                while (!valid_o && n < 50) begin @(negedge clk_i); n++; end
                for (int i = 0; i < 5; i++) begin
                    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got %b required 0", ready_o); end
                    checks++; if (data_o !== 32'h00200000) begin errors++; $display("FAIL stall_data got %h required 00200000", data_o); end
                    @(negedge clk_i);
                end
                @(posedge clk_i); #1;
                ready_i = 1'b1;
            end
        join
        wait_results(2);
        if (got_q.size() == 2) begin
            checks++; if (got_q[0] !== 32'h00200000) begin errors++; $display("FAIL stall_first got %h required 00200000", got_q[0]); end
            checks++; if (got_q[1] !== 32'hFFD00000) begin errors++; $display("FAIL stall_second got %h required FFD00000", got_q[1]); end
        end
    endtask

    task automatic test_random();
        logic [11:0] ba[$], bb[$], qa[$], qb[$];
        logic [10:0] bl[$];
        logic [31:0] exp_main[$];
        logic        exp_sat[$];
        logic [20:0] exp_f11[$];
        int lf, eff;
        longint r;
        bit c;
        bit drv_done;
        drv_done = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 5))
                0: lf = 0;
                1: lf = 1;
                2: lf = $urandom_range(250, 300);
                default: lf = $urandom_range(2, 12);
            endcase
            eff = (lf == 0) ? 1 : ((lf > 256) ? 256 : lf);
            qa.delete(); qb.delete();
            for (int j = 0; j < eff; j++) begin
                qa.push_back(12'($urandom)); qb.push_back(12'($urandom));
                ba.push_back(qa[j]); bb.push_back(qb[j]);
                bl.push_back((j == 0) ? 11'(lf) : 11'($urandom_range(0, 511)));
            end
            r = ref_burst(qa, qb, 22, 32, 1'b1, c);
            exp_main.push_back(r[31:0]); exp_sat.push_back(c);
            r = ref_burst(qa, qb, 11, 21, 1'b1, c);
            exp_f11.push_back(r[20:0]);
        end
        fork
            begin
                for (int i = 0; i < ba.size(); i++) send_beat(ba[i], bb[i], bl[i]);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk_i); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        wait_results(exp_main.size());
        for (int i = 0; i < exp_main.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_main[i]) begin errors++; $display("FAIL rand_data[%0d] got %h required %h", i, got_q[i], exp_main[i]); end
            checks++; if (got_sat_q[i] !== exp_sat[i]) begin errors++; $display("FAIL rand_sat[%0d] got %b required %b", i, got_sat_q[i], exp_sat[i]); end
        end
        checks++; if (f11_q.size() != exp_f11.size()) begin errors++; $display("FAIL rand_f11_count got %0d required %0d", f11_q.size(), exp_f11.size()); end
        for (int i = 0; i < exp_f11.size() && i < f11_q.size(); i++) begin
            checks++; if (f11_q[i] !== exp_f11[i]) begin errors++; $display("FAIL rand_f11[%0d] got %h required %h", i, f11_q[i], exp_f11[i]); end
        end
    endtask

    task automatic test_saturation();
        int n = 0;
        do_reset();
        for (int j = 0; j < 600; j++) send_beat(12'h800, 12'h800, (j == 0) ? 11'd600 : 11'd0);
        @(negedge clk_i);
        while (!big_valid && n < 20) begin @(negedge clk_i); n++; end
        checks++; if (big_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b required 1", big_valid); end
        checks++; if (big_data !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_data got %h required 7FFFFFFF", big_data); end
        checks++; if (big_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b required 1", big_sat); end
        checks++; if (wrap_data !== 32'h96000000) begin errors++; $display("FAIL wrap_data got %h required 96000000", wrap_data); end
        checks++; if (wrap_sat !== 1'b0) begin errors++; $display("FAIL wrap_flag got %b required 0", wrap_sat); end
    endtask

    task automatic test_rounding();
        do_reset();
        send_beat(12'h001, 12'h400, 11'd1);
        send_beat(12'hFFF, 12'h400, 11'd1);
        wait_results(2);
        checks++; if (f11_q.size() != 2) begin errors++; $display("FAIL round_count got %0d required 2", f11_q.size()); end
        if (f11_q.size() == 2 && got_q.size() == 2) begin
            checks++; if (f11_q[0] !== 21'd1) begin errors++; $display("FAIL round_up_pos got %h required 000001", f11_q[0]); end
            checks++; if (f11_q[1] !== 21'd0) begin errors++; $display("FAIL round_up_neg got %h required 000000", f11_q[1]); end
            checks++; if (got_q[0] !== 32'h00000400) begin errors++; $display("FAIL exact_pos got %h required 00000400", got_q[0]); end
            checks++; if (got_q[1] !== 32'hFFFFFC00) begin errors++; $display("FAIL exact_neg got %h required FFFFFC00", got_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_beat(12'h400, 12'h400, 11'd1);
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (data_o !== 32'h00100000) begin errors++; $display("FAIL pre_reset_data got %h required 00100000", data_o); end
        for (int j = 0; j < 3; j++) send_beat(12'h7FF, 12'h7FF, (j == 0) ? 11'd8 : 11'd0);
        #2 reset_i = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b required 0", valid_o); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL async_reset_data got %h required 0", data_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b required 1", ready_o); end
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        got_q.delete(); got_sat_q.delete(); f11_q.delete();
        send_beat(12'h400, 12'h400, 11'd1);
        wait_results(1);
        if (got_q.size() == 1) begin
            checks++; if (got_q[0] !== 32'h00100000) begin errors++; $display("FAIL post_reset_data got %h required 00100000", got_q[0]); end
        end
    endtask

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; len_i = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_random();
        test_saturation();
        test_rounding();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
